// File: rtl/dmem_ctrl_if.sv
// Request/response bundle for dmem_ctrl: valid/ready request side, one-cycle
// response side, and the clear-in-progress status.
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Clocked RV32I data memory: byte/half/word loads and stores with extension,
// fault detection, and an optional one-word-per-cycle clear after reset.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS    = 64,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  dmem_ctrl_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          misaligned;
  logic          bad_size;
  logic          bad_store;
  logic          fault;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rword;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   rsp_next;

  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_fault_q;

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state == CLEAR);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;

  assign accept = bus.req_valid && (state == IDLE);
  assign widx   = bus.req_addr[AW+1:2];
  assign lane   = bus.req_addr[1:0];

  // Power-of-two depth: any set bit above the index field is out of range.
  assign out_of_range = |bus.req_addr[31:AW+2];

  always_comb begin
    misaligned = 1'b0;
    bad_size   = 1'b0;
    bad_store  = 1'b0;
    case (bus.req_funct3)
      3'b000: ;
      3'b001: misaligned = bus.req_addr[0];
      3'b010: misaligned = |bus.req_addr[1:0];
      3'b100: bad_store  = bus.req_we;
      3'b101: begin
        misaligned = bus.req_addr[0];
        bad_store  = bus.req_we;
      end
      default: bad_size = 1'b1;
    endcase
    fault = out_of_range | misaligned | bad_size | bad_store;
  end

  always_comb begin
    be    = 4'b0000;
    wlane = '0;
    case (bus.req_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = bus.req_wdata;
      end
    endcase
  end

  // Reads come from the array as it stands after the previous edge, so a load
  // right behind a store to the same word already sees the new bytes.
  assign rword = mem[widx];
  assign hsel  = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    bsel = rword[7:0];
    case (lane)
      2'd0: bsel = rword[7:0];
      2'd1: bsel = rword[15:8];
      2'd2: bsel = rword[23:16];
      2'd3: bsel = rword[31:24];
      default: bsel = rword[7:0];
    endcase
  end

  always_comb begin
    rsp_next = '0;
    if (!fault && !bus.req_we) begin
      case (bus.req_funct3)
        3'b000:  rsp_next = {{24{bsel[7]}}, bsel};
        3'b001:  rsp_next = {{16{hsel[15]}}, hsel};
        3'b010:  rsp_next = rword;
        3'b100:  rsp_next = {24'h000000, bsel};
        3'b101:  rsp_next = {16'h0000, hsel};
        default: rsp_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_idx     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_rdata_q <= rsp_next;
        rsp_fault_q <= fault;
      end
      if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == '1) begin
          state <= IDLE;
        end
      end
    end
  end

  // Array has no reset so contents survive reset when the clear is disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (accept && bus.req_we && !fault) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[widx][8*i +: 8] <= wlane[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one instance with the post-reset clear and
// one without, directed vectors with hand-computed responses.
module tb_dmem_ctrl;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_X  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        fault;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  dmem_ctrl_if if0();
  dmem_ctrl_if if1();

  dmem_ctrl #(.DEPTH_WORDS(64), .CLEAR_ON_RESET(1'b1)) u_dut0 (
    .clk  (clk),
    .reset(rst0),
    .bus  (if0.slave)
  );

  dmem_ctrl #(.DEPTH_WORDS(64), .CLEAR_ON_RESET(1'b0)) u_dut1 (
    .clk  (clk),
    .reset(rst1),
    .bus  (if1.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic mon_step(input int d, input logic v, input logic [31:0] rd, input logic f);
    exp_t e;
    bit   have;
    while (1) begin
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) break;
      e = (d == 0) ? q0[0] : q1[0];
      if (e.cyc >= cyc) break;
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      vectors++;
      miscompares++;
      $display("FAIL %s: no response, expected in cycle %0d", e.name, e.cyc);
    end
    if (v === 1'b1) begin
      if (!have || e.cyc != cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL dut%0d unexpected response in cycle %0d: rdata %h fault %b", d, cyc, rd, f);
      end else begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk({e.name, " rdata"}, rd, e.rdata);
        chk({e.name, " fault"}, 32'(f), 32'(e.fault));
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, if0.rsp_valid, if0.rsp_rdata, if0.rsp_fault);
    mon_step(1, if1.rsp_valid, if1.rsp_rdata, if1.rsp_fault);
  end

  // Called just after a negedge; returns after the accepting edge's negedge.
  task automatic issue(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_f, input string name);
    exp_t e;
    e.cyc   = cyc + 1;
    e.rdata = exp_rd;
    e.fault = exp_f;
    e.name  = name;
    if (d == 0) begin
      if0.req_valid = 1'b1; if0.req_we = we; if0.req_funct3 = f3;
      if0.req_addr = addr;  if0.req_wdata = wdata;
      q0.push_back(e);
    end else begin
      if1.req_valid = 1'b1; if1.req_we = we; if1.req_funct3 = f3;
      if1.req_addr = addr;  if1.req_wdata = wdata;
      q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int d);
    if (d == 0) if0.req_valid = 1'b0; else if1.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_clear(input string name);
    int n   = 0;
    int bad = 0;
    while (if0.req_ready !== 1'b1 && n < 200) begin
      if (if0.busy !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    chk({name, " clear cycles"}, 32'(n), 32'd64);
    chk({name, " busy during clear"}, 32'(bad), 32'd0);
    chk({name, " busy after clear"}, 32'(if0.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_funct3 = 3'b000;
    if0.req_addr = '0;    if0.req_wdata = '0;
    if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_funct3 = 3'b000;
    if1.req_addr = '0;    if1.req_wdata = '0;

    // ---- instance with clear ----
    @(negedge clk);
    chk("rst busy", 32'(if0.busy), 32'd1);
    chk("rst ready", 32'(if0.req_ready), 32'd0);
    chk("rst rsp_valid", 32'(if0.rsp_valid), 32'd0);
    chk("rst rsp_rdata", if0.rsp_rdata, 32'h0);
    chk("rst rsp_fault", 32'(if0.rsp_fault), 32'd0);
    rst0 = 1'b0;
    count_clear("initial");

    issue(0, 1'b0, F_W,  32'h0000_00FC, 32'h0,         32'h0000_0000, 1'b0, "LW 0xFC cleared");
    issue(0, 1'b1, F_W,  32'h0000_0010, 32'h8000_12F4, 32'h0000_0000, 1'b0, "SW 0x10");
    issue(0, 1'b0, F_B,  32'h0000_0010, 32'h0,         32'hFFFF_FFF4, 1'b0, "LB 0x10");
    issue(0, 1'b0, F_B,  32'h0000_0011, 32'h0,         32'h0000_0012, 1'b0, "LB 0x11");
    issue(0, 1'b0, F_B,  32'h0000_0013, 32'h0,         32'hFFFF_FF80, 1'b0, "LB 0x13");
    issue(0, 1'b0, F_BU, 32'h0000_0013, 32'h0,         32'h0000_0080, 1'b0, "LBU 0x13");
    issue(0, 1'b0, F_H,  32'h0000_0012, 32'h0,         32'hFFFF_8000, 1'b0, "LH 0x12");
    issue(0, 1'b0, F_HU, 32'h0000_0010, 32'h0,         32'h0000_12F4, 1'b0, "LHU 0x10");

    issue(0, 1'b1, F_W,  32'h0000_0020, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, "SW 0x20");
    issue(0, 1'b1, F_B,  32'h0000_0022, 32'hFFFF_FF11, 32'h0000_0000, 1'b0, "SB 0x22");
    issue(0, 1'b1, F_H,  32'h0000_0020, 32'hDEAD_3344, 32'h0000_0000, 1'b0, "SH 0x20");
    issue(0, 1'b0, F_W,  32'h0000_0020, 32'h0,         32'hAA11_3344, 1'b0, "LW 0x20 merged");
    issue(0, 1'b0, F_HU, 32'h0000_0022, 32'h0,         32'h0000_AA11, 1'b0, "LHU 0x22");

    issue(0, 1'b0, F_W,  32'h0000_0021, 32'h0,         32'h0, 1'b1, "LW 0x21 misaligned");
    issue(0, 1'b0, F_H,  32'h0000_0023, 32'h0,         32'h0, 1'b1, "LH 0x23 misaligned");
    issue(0, 1'b1, F_W,  32'h0000_0100, 32'hFFFF_FFFF, 32'h0, 1'b1, "SW 0x100 range");
    issue(0, 1'b1, F_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, "SW 0x80000000 range");
    issue(0, 1'b0, F_W,  32'h8000_0010, 32'h0,         32'h0, 1'b1, "LW 0x80000010 range");
    issue(0, 1'b0, F_X,  32'h0000_0000, 32'h0,         32'h0, 1'b1, "funct3 011");
    issue(0, 1'b1, F_BU, 32'h0000_0000, 32'h0000_0055, 32'h0, 1'b1, "store funct3 100");
    issue(0, 1'b1, F_HU, 32'h0000_0000, 32'h0000_5555, 32'h0, 1'b1, "store funct3 101");
    issue(0, 1'b1, F_H,  32'h0000_0001, 32'h0000_7777, 32'h0, 1'b1, "SH 0x01 misaligned");
    issue(0, 1'b0, F_W,  32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0, "LW 0x0 unchanged");
    issue(0, 1'b0, F_W,  32'h0000_0010, 32'h0,         32'h8000_12F4, 1'b0, "LW 0x10 unchanged");
    idle(0);
    chk("hold rsp_valid", 32'(if0.rsp_valid), 32'd0);
    chk("hold rsp_rdata", if0.rsp_rdata, 32'h8000_12F4);
    chk("hold rsp_fault", 32'(if0.rsp_fault), 32'd0);

    // Reset coinciding with a request: no response, outputs cleared.
    rst0 = 1'b1;
    if0.req_valid = 1'b1; if0.req_we = 1'b0; if0.req_funct3 = F_W;
    if0.req_addr = 32'h0000_0010;
    @(negedge clk);
    if0.req_valid = 1'b0;
    chk("rst+accept rsp_valid", 32'(if0.rsp_valid), 32'd0);
    chk("rst+accept rsp_rdata", if0.rsp_rdata, 32'h0);
    chk("rst+accept busy", 32'(if0.busy), 32'd1);
    rst0 = 1'b0;

    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (if0.busy !== 1'b1 || if0.req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("partial clear busy", 32'(bad), 32'd0);
    rst0 = 1'b1;
    @(negedge clk);
    chk("mid-clear reset busy", 32'(if0.busy), 32'd1);
    chk("mid-clear reset ready", 32'(if0.req_ready), 32'd0);
    rst0 = 1'b0;
    count_clear("restart");
    issue(0, 1'b0, F_W,  32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0, "LW 0x10 recleared");
    issue(0, 1'b0, F_W,  32'h0000_0020, 32'h0, 32'h0000_0000, 1'b0, "LW 0x20 recleared");
    idle(0);

    // ---- instance without clear ----
    chk("noclr rst ready", 32'(if1.req_ready), 32'd1);
    chk("noclr rst busy", 32'(if1.busy), 32'd0);
    rst1 = 1'b0;
    issue(1, 1'b1, F_W,  32'h0000_0008, 32'h1234_5678, 32'h0, 1'b0, "noclr SW 0x8");
    idle(1);
    rst1 = 1'b1;
    @(negedge clk);
    chk("noclr pulse ready", 32'(if1.req_ready), 32'd1);
    chk("noclr pulse busy", 32'(if1.busy), 32'd0);
    chk("noclr pulse rsp_valid", 32'(if1.rsp_valid), 32'd0);
    chk("noclr pulse rsp_rdata", if1.rsp_rdata, 32'h0);
    rst1 = 1'b0;
    issue(1, 1'b0, F_W,  32'h0000_0008, 32'h0, 32'h1234_5678, 1'b0, "noclr LW 0x8 kept");
    idle(1);
    rst1 = 1'b1;
    if1.req_valid = 1'b1; if1.req_we = 1'b1; if1.req_funct3 = F_W;
    if1.req_addr = 32'h0000_0008; if1.req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    if1.req_valid = 1'b0;
    chk("noclr rst+store rsp_valid", 32'(if1.rsp_valid), 32'd0);
    rst1 = 1'b0;
    issue(1, 1'b0, F_W,  32'h0000_0008, 32'h0, 32'h1234_5678, 1'b0, "noclr LW 0x8 no write");
    idle(1);

    repeat (3) @(negedge clk);
    chk("dut0 responses drained", 32'(q0.size()), 32'd0);
    chk("dut1 responses drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
